id_ex_stage: RTL and testbench

- ID→EX pipeline register of the RISC-V core, directly downstream of the register file. Captures read data rd1/rd2, the operand addresses, immediate, PC and decoded control.
- Detects load-use hazards against the instruction currently held in EX and inserts a bubble.
- Provides a valid/ready handshake with stall and flush to ID upstream and to EX downstream.

---
 rtl/id_ex_stage.sv | 123 ++++++++++++
 tb/tb_id_ex_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection, valid/ready handshake, stall and flush.
// Latency 1 cycle; holds on EX back-pressure. Optional counters under ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic [4:0]          id_rd,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [XLEN-1:0]     id_rd1,
  input  logic [XLEN-1:0]     id_rd2,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_alu_src,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_reg_write,
  input  logic                flush,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_rd1,
  output logic [XLEN-1:0]     ex_rd2,
  output logic [XLEN-1:0]     ex_imm,
  output logic [4:0]          ex_rs1,
  output logic [4:0]          ex_rs2,
  output logic [4:0]          ex_rd,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_alu_src,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_reg_write,
`ifdef ID_EX_PERF_CNT_EN
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt,
`endif
  output logic                load_use_stall
);

  logic hazard;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real producer, so a load to x0 cannot create a dependency.
  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign hazard  = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

  assign load_use_stall = hazard;
  assign id_ready       = (!ex_valid || ex_ready) && !hazard && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rd1       <= '0;
      ex_rd2       <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_alu_op    <= '0;
      ex_alu_src   <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (ex_valid && !ex_ready) begin
      ex_valid     <= ex_valid;
    end else if (id_valid && id_ready) begin
      ex_valid     <= 1'b1;
      ex_pc        <= id_pc;
      ex_rd1       <= id_rd1;
      ex_rd2       <= id_rd2;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_alu_op    <= id_alu_op;
      ex_alu_src   <= id_alu_src;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      ex_reg_write <= id_reg_write;
    end else begin
      // Bubble: only control is cleared, data fields keep their last value.
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && ex_valid && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  // Counter width only matters when the counters exist.
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, streaming, load-use, x0, back-pressure, flush, async reset.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int ALU_OP_W = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic id_valid, id_ready;
  logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic id_uses_rs1, id_uses_rs2;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic id_alu_src, id_mem_read, id_mem_write, id_reg_write;
  logic flush, ex_ready, ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic load_use_stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
`ifdef ID_EX_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .load_use_stall(load_use_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic u1, input logic u2,
                     input logic mr, input logic mw, input logic rw);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
    id_rd1 = pc + 32'h100; id_rd2 = pc + 32'h200; id_imm = pc + 32'h300;
    id_alu_op = pc[5:2]; id_alu_src = pc[2];
  endtask

  initial begin
    // Reset with random inputs, checked before any clock edge.
    reset_n = 1'b0;
    id_valid = 1'b1; id_pc = $urandom; id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_alu_op = 4'($urandom); id_alu_src = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1; id_reg_write = 1'b1;
    flush = 1'b0; ex_ready = 1'b1;
    #2;
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_ex_pc", ex_pc, 0);
    check("rst_ex_rd1", ex_rd1, 0);
    check("rst_ex_ctrl", {29'd0, ex_mem_read, ex_mem_write, ex_reg_write}, 0);
    check("rst_ex_rd", 32'(ex_rd), 0);
    tick();
    check("rst_hold_valid", 32'(ex_valid), 0);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_id_ready", 32'(id_ready), 1);

    // Streaming four instructions back to back.
    tick();
    for (int i = 0; i < 4; i++) begin
      put(1, 32'(i * 4), 5'(i + 1), 5'(i + 2), 5'(i + 3), 1, 1, 0, 0, 1);
      id_rd1 = 32'h11 + 32'(i);
      #1;
      check("str_id_ready", 32'(id_ready), 1);
      tick();
      check("str_ex_valid", 32'(ex_valid), 1);
      check("str_ex_pc", ex_pc, 32'(i * 4));
      check("str_ex_rd1", ex_rd1, 32'h11 + 32'(i));
    end
    check("str_ex_rd", 32'(ex_rd), 6);
    put(0, 32'h30, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("idle_bubble", 32'(ex_valid), 0);
    check("idle_data_hold", ex_pc, 32'hC);

    // Load-use: lw x5 then add x6,x5,x7.
    put(1, 32'h40, 1, 0, 5, 1, 0, 1, 0, 1);
    tick();
    check("lu_ex_mem_read", 32'(ex_mem_read), 1);
    put(1, 32'h44, 5, 7, 6, 1, 1, 0, 0, 1);
    #1;
    check("lu_stall", 32'(load_use_stall), 1);
    check("lu_id_ready", 32'(id_ready), 0);
    tick();
    check("lu_bubble_valid", 32'(ex_valid), 0);
    check("lu_bubble_mr", 32'(ex_mem_read), 0);
    check("lu_bubble_rw", 32'(ex_reg_write), 0);
    check("lu_bubble_pc_hold", ex_pc, 32'h40);
    check("lu_stall_clear", 32'(load_use_stall), 0);
    check("lu_ready_again", 32'(id_ready), 1);
    tick();
    check("lu_accept_valid", 32'(ex_valid), 1);
    check("lu_accept_rs1", 32'(ex_rs1), 5);
    check("lu_accept_pc", ex_pc, 32'h44);

    // lw x0 followed by a reader of x0: no stall.
    put(1, 32'h50, 1, 0, 0, 1, 0, 1, 0, 1);
    tick();
    put(1, 32'h54, 0, 0, 8, 1, 1, 0, 0, 1);
    #1;
    check("x0_no_stall", 32'(load_use_stall), 0);
    check("x0_id_ready", 32'(id_ready), 1);
    tick();
    check("x0_pc", ex_pc, 32'h54);

    // lw x5 then an instruction carrying rs1=5 that does not read it.
    put(1, 32'h58, 1, 0, 5, 1, 0, 1, 0, 1);
    tick();
    put(1, 32'h5C, 5, 3, 9, 0, 1, 0, 0, 1);
    #1;
    check("nors1_no_stall", 32'(load_use_stall), 0);
    tick();
    check("nors1_pc", ex_pc, 32'h5C);
    check("nors1_valid", 32'(ex_valid), 1);

    // Back-pressure with 0x20 held in EX.
    put(1, 32'h20, 1, 2, 3, 1, 1, 0, 0, 1);
    tick();
    check("bp_load_pc", ex_pc, 32'h20);
    ex_ready = 1'b0;
    put(1, 32'h24, 1, 2, 3, 1, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_id_ready", 32'(id_ready), 0);
      tick();
      check("bp_hold_pc", ex_pc, 32'h20);
      check("bp_hold_valid", 32'(ex_valid), 1);
      check("bp_hold_rd1", ex_rd1, 32'h120);
    end
    ex_ready = 1'b1;
    #1;
    check("bp_resume_ready", 32'(id_ready), 1);
    tick();
    check("bp_resume_pc", ex_pc, 32'h24);

    // Flush while EX is valid and ID offers an instruction.
    flush = 1'b1;
    put(1, 32'h28, 1, 2, 4, 1, 1, 0, 0, 1);
    #1;
    check("fl_id_ready", 32'(id_ready), 0);
    tick();
    flush = 1'b0;
    check("fl_valid", 32'(ex_valid), 0);
    check("fl_reg_write", 32'(ex_reg_write), 0);
    check("fl_mem_write", 32'(ex_mem_write), 0);
    check("fl_not_consumed", ex_pc, 32'h24);
`ifdef ID_EX_PERF_CNT_EN
    check("cnt_flush", 32'(flush_cnt), 1);
    check("cnt_stall", 32'(stall_cnt), 1);
`endif
    #1;
    check("fl_ready_after", 32'(id_ready), 1);
    tick();
    check("fl_then_accept", ex_pc, 32'h28);

    // Asynchronous reset mid-transfer, between clock edges.
    put(1, 32'h2C, 1, 2, 4, 1, 1, 1, 1, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(ex_valid), 0);
    check("arst_pc", ex_pc, 0);
    check("arst_ctrl", {29'd0, ex_mem_read, ex_mem_write, ex_reg_write}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("arst_after_valid", 32'(ex_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
